// File: rtl/gpio2_melody_seq_if.sv
// Bus bundle for the gpio2 melody sequencer: note-table write port,
// playback controls and the buzzer-facing status outputs.
interface gpio2_melody_seq_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              start;
  logic              stop;
  logic              loop;
  logic [31:0]       buzz_ctrl;
  logic              busy;
  logic [ADDR_W-1:0] cur_addr;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop,
    input  buzz_ctrl, busy, cur_addr, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop,
    output buzz_ctrl, busy, cur_addr, done
  );
endinterface

// File: rtl/gpio2_melody_seq.sv
// Note sequencer driving the gpio2 buzzer control word. Walks a CPU-loaded
// table of (duration, half-period) entries, holding each note for its
// duration and inserting a silent gap between notes.
module gpio2_melody_seq #(
  parameter int ADDR_W      = 4,
  parameter int TICK_CYCLES = 33000,
  parameter int GAP_TICKS   = 10
) (
  input  logic               clk,
  input  logic               resetn,
  gpio2_melody_seq_if.slave  bus
);
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam bit HAS_GAP  = (GAP_TICKS > 0);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [31:0]       buzz_q;
  logic              done_q;
  logic [PRE_W-1:0]  pre_q;
  logic [11:0]       dur_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rd_q;

  logic [11:0]       ent_dur;
  logic [19:0]       ent_hp;
  logic              tick_end;
  logic              last_addr;
  logic              end_restart;
  state_t            fin_state_d;
  logic [ADDR_W-1:0] fin_addr_d;
  logic              fin_done_d;

  assign ent_dur   = rd_q[31:20];
  assign ent_hp    = rd_q[19:0];
  assign tick_end  = (pre_q == PRE_W'(TICK_CYCLES - 1));
  assign last_addr = (cur_addr_q == ADDR_W'(DEPTH - 1));
  // A marker sitting at entry 0 means an empty song; looping it would spin forever.
  assign end_restart = bus.loop && !(state_q == S_LOAD && cur_addr_q == '0);

  // Table RAM: read-first, so a write to the address being fetched returns old data.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    if (state_q == S_FETCH) rd_q <= mem_q[cur_addr_q];
  end

  // Where to go once a note (or end marker) is finished: advance, restart or stop.
  always_comb begin
    fin_state_d = S_IDLE;
    fin_addr_d  = cur_addr_q;
    fin_done_d  = 1'b1;
    if (state_q != S_LOAD && !last_addr) begin
      fin_state_d = S_FETCH;
      fin_addr_d  = cur_addr_q + 1'b1;
      fin_done_d  = 1'b0;
    end else if (end_restart) begin
      fin_state_d = S_FETCH;
      fin_addr_d  = '0;
      fin_done_d  = 1'b0;
    end
  end

  // Playback FSM with registered buzzer word, address and done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      buzz_q     <= '0;
      done_q     <= 1'b0;
      pre_q      <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q <= S_IDLE;
        buzz_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              cur_addr_q <= '0;
              state_q    <= S_FETCH;
            end
          end
          S_FETCH: state_q <= S_LOAD;
          S_LOAD: begin
            if (ent_dur == 12'd0) begin
              state_q    <= fin_state_d;
              cur_addr_q <= fin_addr_d;
              done_q     <= fin_done_d;
            end else begin
              buzz_q    <= {(ent_hp != 20'd0), 11'b0, ent_hp};
              pre_q     <= '0;
              dur_cnt_q <= ent_dur;
              state_q   <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (tick_end) begin
              pre_q     <= '0;
              dur_cnt_q <= dur_cnt_q - 12'd1;
              if (dur_cnt_q == 12'd1) begin
                buzz_q <= '0;
                if (HAS_GAP) begin
                  gap_cnt_q <= GAP_W'(GAP_TICKS);
                  state_q   <= S_GAP;
                end else begin
                  state_q    <= fin_state_d;
                  cur_addr_q <= fin_addr_d;
                  done_q     <= fin_done_d;
                end
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          S_GAP: begin
            if (tick_end) begin
              pre_q     <= '0;
              gap_cnt_q <= gap_cnt_q - 1'b1;
              if (gap_cnt_q == GAP_W'(1)) begin
                state_q    <= fin_state_d;
                cur_addr_q <= fin_addr_d;
                done_q     <= fin_done_d;
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.buzz_ctrl = buzz_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cur_addr  = cur_addr_q;
  assign bus.done      = done_q;
endmodule
